// File: rtl/axis_dma_read.sv
`default_nettype none
// ============================================================================
// Module   : axis_dma_read
// Purpose  : Memory-to-stream DMA read engine. It issues one byte read per
//            cycle for base_addr .. base_addr+length-1, buffers the in-order
//            responses in a credit-managed prefetch FIFO and emits them on an
//            8-bit AXI-Stream master with full backpressure support.
// Options  : DMA_RD_TLAST_EN - adds M_AXIS_TLAST, marking the final byte.
// Revision : 1.0 - initial release
// ============================================================================
module axis_dma_read #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             mem_rd_req,
  output logic [31:0]      mem_rd_addr,
  input  logic             mem_rd_resp_valid,
  input  logic [7:0]       mem_rd_data,
  output logic             M_AXIS_TVALID,
  output logic [7:0]       M_AXIS_TDATA,
  input  logic             M_AXIS_TREADY
`ifdef DMA_RD_TLAST_EN
  ,
  output logic             M_AXIS_TLAST
`endif
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_occ_w = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_occ_w:0] c_depth = (c_occ_w + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  logic [31:0]          r_base;
  logic [CNT_W-1:0]     r_len;
  logic [CNT_W-1:0]     r_issued;
  logic [CNT_W-1:0]     r_sent;
  logic [c_occ_w-1:0]   r_outstanding;
  logic [c_occ_w-1:0]   r_fifo_count;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [7:0]           r_fifo_mem [FIFO_DEPTH];

  logic                 w_start_ok;
  logic                 w_push;
  logic                 w_pop;
  logic [c_occ_w:0]     w_credit;
  logic                 w_issue;
  logic                 w_last_beat;

  assign w_start_ok    = (r_state == ST_IDLE) && start;
  // Responses seen while idle are leftovers from an aborted transfer: drop them.
  assign w_push        = mem_rd_resp_valid && (r_state != ST_IDLE);
  assign M_AXIS_TVALID = (r_fifo_count != '0);
  assign M_AXIS_TDATA  = r_fifo_mem[r_rd_ptr];
  assign w_pop         = M_AXIS_TVALID && M_AXIS_TREADY;
  // A byte leaving the FIFO this cycle frees its slot before any new request
  // can return data (latency >= 1), so it is credited back immediately; this
  // keeps back-to-back requests flowing without ever exceeding FIFO_DEPTH.
  assign w_credit      = {1'b0, r_outstanding} + {1'b0, r_fifo_count}
                         - {{c_occ_w{1'b0}}, w_pop};
  assign w_issue       = (r_state == ST_ISSUE) && (r_issued < r_len)
                         && (w_credit < c_depth);
  assign w_last_beat   = w_pop && ((r_sent + CNT_W'(1)) == r_len);
  assign busy          = (r_state != ST_IDLE);

`ifdef DMA_RD_TLAST_EN
  assign M_AXIS_TLAST  = M_AXIS_TVALID && (r_sent == (r_len - CNT_W'(1)));
`endif

  // Transfer control: start/length capture, request generation, completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_sent      <= '0;
      done        <= 1'b0;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          mem_rd_req <= 1'b0;
          if (start) begin
            r_base   <= base_addr;
            r_len    <= length;
            r_issued <= '0;
            r_sent   <= '0;
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          mem_rd_req <= w_issue;
          if (w_issue) begin
            mem_rd_addr <= r_base + 32'(r_issued);
            r_issued    <= r_issued + CNT_W'(1);
            if ((r_issued + CNT_W'(1)) == r_len) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          mem_rd_req <= 1'b0;
        end
        default: begin
          mem_rd_req <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
      if ((r_state != ST_IDLE) && w_pop) begin
        r_sent <= r_sent + CNT_W'(1);
      end
      if ((r_state != ST_IDLE) && w_last_beat) begin
        r_state <= ST_IDLE;
        done    <= 1'b1;
      end
    end
  end

  // Reads in flight: up on each request, down on each accepted response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else if (w_start_ok) begin
      r_outstanding <= '0;
    end else begin
      case ({w_issue, w_push})
        2'b10:   r_outstanding <= r_outstanding + c_occ_w'(1);
        2'b01:   r_outstanding <= r_outstanding - c_occ_w'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Prefetch FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else if (w_start_ok) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + c_occ_w'(1);
        2'b01:   r_fifo_count <= r_fifo_count - c_occ_w'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // FIFO storage; data needs no reset because TVALID gates its use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= mem_rd_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_dma_read.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_dma_read
// Purpose  : Self-checking bench for axis_dma_read. A latency-configurable
//            memory model answers reads; expected addresses and bytes are
//            queued when a transfer is started and compared as the DUT
//            produces them. Define DMA_RD_TLAST_EN to also check TLAST.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axis_dma_read;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] length = '0;
  logic        busy, done, mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_resp_valid = 1'b0;
  logic [7:0]  mem_rd_data = '0;
  logic        M_AXIS_TVALID;
  logic [7:0]  M_AXIS_TDATA;
  logic        M_AXIS_TREADY = 1'b1;
`ifdef DMA_RD_TLAST_EN
  logic        M_AXIS_TLAST;
  logic        prev_last = 1'b0;
`endif

  axis_dma_read #(.FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .mem_rd_req(mem_rd_req),
    .mem_rd_addr(mem_rd_addr), .mem_rd_resp_valid(mem_rd_resp_valid),
    .mem_rd_data(mem_rd_data), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TREADY(M_AXIS_TREADY)
`ifdef DMA_RD_TLAST_EN
    , .M_AXIS_TLAST(M_AXIS_TLAST)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    int          len;
    int          lat;
    int          rmode;      // 0: always ready, 1: 20-cycle stall, 2: random
    logic [7:0]  exp_first;
    logic [31:0] exp_last_addr;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] d;
  } pend_t;

  vec_t        tbl [6];
  pend_t       pend_q [$];
  logic [31:0] exp_addr_q [$];
  logic [7:0]  exp_data_q [$];

  int checks = 0, failures = 0;
  int cyc = 0, lat = 2, rmode = 0, stall_until = 0;
  int start_cyc = 0, exp_done_cyc = -1, done_cnt = 0;
  int reqs_seen = 0, beats_seen = 0;
  int first_req_cyc = 0, last_req_cyc = 0, first_hs = 0, last_hs = 0;
  bit first_req_pend = 1'b0;
  logic [7:0]  first_data = '0;
  logic [31:0] last_addr = '0;
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: in-order responses, fixed latency lat, data = addr[7:0]^0x5A.
  initial forever begin
    @(posedge clk); #1;
    mem_rd_resp_valid = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      mem_rd_resp_valid = 1'b1;
      mem_rd_data = pend_q[0].d;
      void'(pend_q.pop_front());
    end
    if (mem_rd_req) pend_q.push_back('{cyc + lat, mem_rd_addr[7:0] ^ 8'h5A});
  end

  // Downstream ready pattern.
  initial forever begin
    @(posedge clk); #1;
    if (cyc < stall_until)  M_AXIS_TREADY = 1'b0;
    else if (rmode == 2)    M_AXIS_TREADY = 1'($urandom_range(0, 1));
    else                    M_AXIS_TREADY = 1'b1;
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [7:0]  ed;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (mem_rd_req) begin
        reqs_seen++;
        if (exp_addr_q.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          ea = exp_addr_q.pop_front();
          chk("req_addr", mem_rd_addr, ea);
        end
        if (first_req_pend) begin
          chk("start_to_req", cyc - start_cyc, 2);
          first_req_pend = 1'b0;
          first_req_cyc = cyc;
        end
        last_req_cyc = cyc;
        last_addr = mem_rd_addr;
        chk("credit_cap", (reqs_seen - beats_seen) <= DEPTH, 1);
      end
      if (prev_valid && !prev_ready) begin
        chk("tvalid_hold", M_AXIS_TVALID, 1);
        chk("tdata_hold", M_AXIS_TDATA, prev_data);
`ifdef DMA_RD_TLAST_EN
        chk("tlast_hold", M_AXIS_TLAST, prev_last);
`endif
      end
`ifdef DMA_RD_TLAST_EN
      if (M_AXIS_TVALID) chk("tlast", M_AXIS_TLAST, exp_data_q.size() == 1);
`endif
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_data_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          ed = exp_data_q.pop_front();
          chk("tdata", M_AXIS_TDATA, ed);
          if (beats_seen == 0) begin
            first_data = M_AXIS_TDATA;
            first_hs = cyc;
          end
          if (exp_data_q.size() == 0) begin
            exp_done_cyc = cyc + 1;
            last_hs = cyc;
          end
        end
        beats_seen++;
      end
      if (done || cyc == exp_done_cyc) chk("done_timing", done && (cyc == exp_done_cyc), 1);
      if (done) done_cnt++;
      prev_valid = M_AXIS_TVALID;
      prev_ready = M_AXIS_TREADY;
      prev_data  = M_AXIS_TDATA;
`ifdef DMA_RD_TLAST_EN
      prev_last  = M_AXIS_TLAST;
`endif
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req"}, mem_rd_req, 0);
    chk({tag, "_addr"}, mem_rd_addr, 0);
    chk({tag, "_tvalid"}, M_AXIS_TVALID, 0);
  endtask

  task automatic run_xfer(input int idx);
    vec_t r;
    int   d0, n;
    r = tbl[idx];
    lat = r.lat;
    rmode = r.rmode;
    for (int i = 0; i < r.len; i++) begin
      logic [31:0] a;
      a = r.base + 32'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(a[7:0] ^ 8'h5A);
    end
    reqs_seen = 0;
    beats_seen = 0;
    d0 = done_cnt;
    start = 1'b1;
    base_addr = r.base;
    length = 32'(r.len);
    start_cyc = cyc;
    first_req_pend = (r.len != 0);
    exp_done_cyc = (r.len == 0) ? cyc + 1 : -1;
    if (rmode == 1) stall_until = cyc + 20;
    if (r.len == 0) begin
      @(negedge clk);
      chk("len0_busy", busy, 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("addr_left", exp_addr_q.size(), 0);
    chk("data_left", exp_data_q.size(), 0);
    chk("busy_after", busy, 0);
    if (r.len > 0) begin
      chk("first_byte", first_data, r.exp_first);
      chk("last_addr", last_addr, r.exp_last_addr);
      if (rmode == 0) begin
        chk("first_beat_lat", first_hs - start_cyc, 3 + lat);
        chk("stream_rate", last_hs - first_hs, r.len - 1);
        chk("req_rate", last_req_cyc - first_req_cyc, r.len - 1);
      end
    end
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    int d0, n;
    tbl[0] = '{32'h0000_0100,  4, 2, 0, 8'h5A, 32'h0000_0103};
    tbl[1] = '{32'h0000_0200, 16, 2, 1, 8'h5A, 32'h0000_020F};
    tbl[2] = '{32'h0000_0300,  0, 2, 0, 8'h00, 32'h0000_0000};
    tbl[3] = '{32'hFFFF_FFFE,  4, 3, 2, 8'hA4, 32'h0000_0001};
    tbl[4] = '{32'h0000_0040,  3, 1, 2, 8'h1A, 32'h0000_0042};
    tbl[5] = '{32'h0000_0080, 12, 2, 0, 8'hDA, 32'h0000_008B};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_xfer(i);

    // Abort mid-transfer, with an ignored start while busy.
    lat = 3;
    rmode = 0;
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(32'h500 + 32'(i));
      exp_data_q.push_back(8'(32'h500 + 32'(i)) ^ 8'h5A);
    end
    reqs_seen = 0;
    beats_seen = 0;
    d0 = done_cnt;
    start = 1'b1; base_addr = 32'h500; length = 32'd8;
    start_cyc = cyc; first_req_pend = 1'b1; exp_done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 32'h900; length = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (beats_seen < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reached", beats_seen >= 3, 1);
    rst_n = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_done_cyc = -1;
    @(negedge clk);
    check_idle_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stale_tvalid", M_AXIS_TVALID, 0);
      chk("stale_req", mem_rd_req, 0);
      chk("stale_busy", busy, 0);
    end
    chk("abort_no_done", done_cnt - d0, 0);
    n = 0;
    while (pend_q.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    run_xfer(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
